// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: EX-stage sequencer for an iterative unsigned divider; owns HI/LO and the divide stall.
// Ports: clock/reset (async, active-high); req_valid/req_ready/req_op/req_a/req_b from EX;
// dv_dividend/dv_divisor/dv_start to the core, dv_busy/dv_q/dv_r from it;
// hi/lo architectural registers; stall pipeline hold; done one-cycle write pulse; err sticky timeout.
module div_hilo_ctrl #(
  parameter int TIMEOUT = 48
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] dv_dividend,
  output logic [31:0] dv_divisor,
  output logic        dv_start,
  input  logic        dv_busy,
  input  logic [31:0] dv_q,
  input  logic [31:0] dv_r,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall,
  output logic        done,
  output logic        err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;
  localparam int TW = $clog2(TIMEOUT);
  logic [1:0]    state_q, state_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d, dvd_q, dvd_d, dvs_q, dvs_d, q_q, q_d, r_q, r_d;
  logic          qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d, err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          is_mt, is_signed, div_go;
  logic [31:0]   abs_a, abs_b;
  assign is_mt     = req_op[1];
  assign is_signed = req_op == 2'b01;
  // Two's-complement abs; 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign abs_a     = (is_signed & req_a[31]) ? -req_a : req_a;
  assign abs_b     = (is_signed & req_b[31]) ? -req_b : req_b;
  assign div_go    = state_q == S_IDLE & req_valid & ~is_mt & req_b != 32'd0;
  assign req_ready = state_q == S_IDLE;
  assign dv_start  = state_q == S_ISSUE;
  assign stall     = state_q != S_IDLE | div_go;
  assign dv_dividend = dvd_q;
  assign dv_divisor  = dvs_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;
  assign err  = err_q;
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid & is_mt) begin
          hi_d   = req_op[0] ? hi_q : req_a;
          lo_d   = req_op[0] ? req_a : lo_q;
          done_d = 1'b1;
        end else if (req_valid & req_b == 32'd0) begin
          hi_d   = req_a;
          lo_d   = 32'hFFFF_FFFF;
          done_d = 1'b1;
        end else if (req_valid) begin
          dvd_d   = abs_a;
          dvs_d   = abs_b;
          qneg_d  = is_signed & (req_a[31] ^ req_b[31]);
          rneg_d  = is_signed & req_a[31];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!dv_busy) begin
          q_d     = dv_q;
          r_d     = dv_r;
          state_d = S_WRITE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        lo_d    = qneg_q ? -q_q : q_q;
        hi_d    = rneg_q ? -r_q : r_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      timer_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_div_hilo_ctrl.sv
// tb_div_hilo_ctrl: directed-vector bench for div_hilo_ctrl with a 32-cycle divider core model.
module tb_div_hilo_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0, req_b = '0;
  logic [31:0] dv_dividend, dv_divisor, dv_q, dv_r, hi, lo;
  logic        dv_start, dv_busy, stall, done, err;
  logic        hang = 1'b0;
  logic [5:0]  core_cnt;
  int          vectors = 0, miscompares = 0;
  int          start_total = 0, done_total = 0;
  int          stall_cnt, pre_stall, s0, d0;
  div_hilo_ctrl #(.TIMEOUT(48)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .dv_dividend(dv_dividend), .dv_divisor(dv_divisor), .dv_start(dv_start),
    .dv_busy(dv_busy), .dv_q(dv_q), .dv_r(dv_r),
    .hi(hi), .lo(lo), .stall(stall), .done(done), .err(err)
  );
  always #5 clock = ~clock;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      dv_busy  <= 1'b0;
      core_cnt <= '0;
      dv_q     <= '0;
      dv_r     <= '0;
    end else if (dv_start) begin
      dv_busy  <= 1'b1;
      core_cnt <= 6'd31;
      dv_q     <= dv_divisor == 0 ? 32'd0 : dv_dividend / dv_divisor;
      dv_r     <= dv_divisor == 0 ? 32'd0 : dv_dividend % dv_divisor;
    end else if (dv_busy && !hang) begin
      if (core_cnt == 0) dv_busy <= 1'b0;
      else core_cnt <= core_cnt - 1'b1;
    end
  end
  always @(posedge clock) begin
    if (dv_start) start_total <= start_total + 1;
    if (done) done_total <= done_total + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    s0 = start_total;
    d0 = done_total;
    #1 pre_stall = int'(stall);
    check("ready_idle", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit seen = 0;
    issue(op, a, b);
    stall_cnt = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (stall) stall_cnt++;
        @(posedge clock);
        #1;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    @(posedge clock);
    #1 check("done_pulse", 32'(done), 32'd0);
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_flags", {28'd0, done, err, dv_start, stall}, 32'd0);
    @(negedge clock) reset = 1'b0;
    run(2'b00, 32'd100, 32'd7);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    check("divu_stall_cycles", 32'(stall_cnt), 32'd35);
    check("divu_pre_stall", 32'(pre_stall), 32'd1);
    check("divu_starts", 32'(start_total - s0), 32'd1);
    check("divu_dones", 32'(done_total - d0), 32'd1);
    run(2'b01, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_lo", lo, 32'hFFFF_FFFD);
    check("div_m7_2_hi", hi, 32'hFFFF_FFFF);
    run(2'b01, 32'd7, 32'hFFFF_FFFE);
    check("div_7_m2_lo", lo, 32'hFFFF_FFFD);
    check("div_7_m2_hi", hi, 32'd1);
    run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_lo", lo, 32'h8000_0000);
    check("div_min_hi", hi, 32'd0);
    run(2'b01, 32'hFFFF_FF9C, 32'd7);
    check("div_m100_7_lo", lo, 32'hFFFF_FFF2);
    check("div_m100_7_hi", hi, 32'hFFFF_FFFE);
    run(2'b00, 32'd5, 32'd0);
    check("dz_lo", lo, 32'hFFFF_FFFF);
    check("dz_hi", hi, 32'd5);
    check("dz_stall", 32'(stall_cnt + pre_stall), 32'd0);
    check("dz_starts", 32'(start_total - s0), 32'd0);
    run(2'b10, 32'd1234, 32'd0);
    check("mthi_stall", 32'(stall_cnt + pre_stall), 32'd0);
    check("mthi_done", 32'(done_total - d0), 32'd1);
    run(2'b11, 32'd5678, 32'd9);
    check("mtlo_stall", 32'(stall_cnt + pre_stall), 32'd0);
    check("mtlo_done", 32'(done_total - d0), 32'd1);
    check("mt_hi", hi, 32'd1234);
    check("mt_lo", lo, 32'd5678);
    issue(2'b00, 32'd1000, 32'd10);
    repeat (11) @(posedge clock);
    #1;
    check("mid_ready", 32'(req_ready), 32'd0);
    check("mid_hi_kept", hi, 32'd1234);
    reset = 1'b1;
    #1;
    check("async_rst_hilo", hi | lo, 32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd1);
    check("async_rst_stall", 32'(stall), 32'd0);
    @(negedge clock) reset = 1'b0;
    run(2'b00, 32'd9, 32'd3);
    check("post_rst_lo", lo, 32'd3);
    check("post_rst_hi", hi, 32'd0);
    run(2'b10, 32'hCAFE_0001, 32'd0);
    hang = 1'b1;
    issue(2'b00, 32'd50, 32'd5);
    begin
      int lat = 0;
      for (int i = 1; i <= 100 && lat == 0; i++) begin
        @(posedge clock);
        #1 if (err) lat = i;
      end
      check("timeout_latency", 32'(lat), 32'd49);
    end
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_hi", hi, 32'hCAFE_0001);
    check("timeout_lo", lo, 32'd3);
    check("timeout_ready", 32'(req_ready), 32'd1);
    check("timeout_no_done", 32'(done_total - d0), 32'd0);
    repeat (3) @(posedge clock);
    #1 check("err_sticky", 32'(err), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
